// File: rtl/floppy_emu_pkg.sv
// Shared timing constants and helpers for the floppy emulator write-path decoder.
// Cell timing is derived from the number of clocks per 2 us GCR bit cell.
package floppy_emu_pkg;

  localparam int CELL_CLKS_DEF   = 14;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 5;

  // What the cell timer decided this clock.
  typedef enum logic [1:0] {
    CELL_WAIT = 2'd0,
    CELL_EDGE = 2'd1,
    CELL_ZERO = 2'd2
  } cellEvent_t;

  // A missing transition is declared 1.5 cells after the previous bit.
  function automatic int zeroTrig(input int cellClks);
    return cellClks + cellClks / 2 - 1;
  endfunction

  // Reload so that further zeros land one full cell apart while idle.
  function automatic int reloadVal(input int cellClks);
    return cellClks / 2;
  endfunction

  localparam int ZERO_TRIG = zeroTrig(CELL_CLKS_DEF);
  localparam int RELOAD    = reloadVal(CELL_CLKS_DEF);

endpackage

// File: rtl/floppy_emu_if.sv
// Write-path bundle: host WR line in, decoded GCR byte and toggle strobe out.
// master = host/microcontroller side, slave = decoder.
interface floppy_emu_if;
  logic       wr;
  logic [7:0] wrData;
  logic       rdAckWrByte;

  modport master (output wr, input wrData, input rdAckWrByte);
  modport slave  (input wr, output wrData, output rdAckWrByte);
endinterface

// File: rtl/floppy_emu_wr_edge_sync.sv
// Synchronises the asynchronous WR line and emits a one-clock pulse on
// every transition of either polarity.
module wr_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  output logic edgePulse
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   wrPrevReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncReg   <= '0;
      wrPrevReg <= 1'b0;
    end else begin
      syncReg   <= {syncReg[SYNC_STAGES-2:0], wr};
      wrPrevReg <= syncReg[SYNC_STAGES-1];
    end
  end

  assign edgePulse = syncReg[SYNC_STAGES-1] ^ wrPrevReg;

endmodule

// File: rtl/floppy_emu.sv
// GCR write-path decoder: recovers bits from WR transitions and frames
// self-synchronising bytes (MSB set) for the microcontroller.
module floppy_emu
  import floppy_emu_pkg::*;
#(
  parameter int CELL_CLKS   = CELL_CLKS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  floppy_emu_if.slave   bus
);

  localparam logic [CNT_W-1:0] ZERO_AT   = CNT_W'(zeroTrig(CELL_CLKS));
  localparam logic [CNT_W-1:0] RELOAD_AT = CNT_W'(reloadVal(CELL_CLKS));

  logic             edgePulse;
  cellEvent_t       cellEvt;
  logic [CNT_W-1:0] cntReg,    cntNext;
  logic [7:0]       shReg,     shNext;
  logic [7:0]       wrDataReg, wrDataNext;
  logic             ackReg,    ackNext;
  logic [7:0]       shiftVal;

  wr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uEdge (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (bus.wr),
    .edgePulse (edgePulse)
  );

  // A transition always wins over a pending zero in the same clock.
  always_comb begin
    cellEvt = CELL_WAIT;
    if (edgePulse) begin
      cellEvt = CELL_EDGE;
    end else if (cntReg == ZERO_AT) begin
      cellEvt = CELL_ZERO;
    end
  end

  always_comb begin
    cntNext    = cntReg + 1'b1;
    shNext     = shReg;
    wrDataNext = wrDataReg;
    ackNext    = ackReg;
    shiftVal   = {shReg[6:0], (cellEvt == CELL_EDGE)};

    if (cellEvt == CELL_EDGE) begin
      cntNext = '0;
    end else if (cellEvt == CELL_ZERO) begin
      cntNext = RELOAD_AT;
    end

    // Zeros into an empty shifter stay zero, so gaps are absorbed and
    // framing locks onto the next leading one.
    if (cellEvt != CELL_WAIT) begin
      if (shiftVal[7]) begin
        wrDataNext = shiftVal;
        ackNext    = ~ackReg;
        shNext     = '0;
      end else begin
        shNext     = shiftVal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntReg    <= '0;
      shReg     <= '0;
      wrDataReg <= 8'h00;
      ackReg    <= 1'b0;
    end else begin
      cntReg    <= cntNext;
      shReg     <= shNext;
      wrDataReg <= wrDataNext;
      ackReg    <= ackNext;
    end
  end

  assign bus.wrData      = wrDataReg;
  assign bus.rdAckWrByte = ackReg;

endmodule

// File: tb/tb_floppy_emu.sv
// Bench for floppy_emu: drives GCR bit cells on WR and compares decoded bytes
// against a bit-list framing model.
`timescale 1ns/1ps
module tb_floppy_emu;

  logic clk = 1'b0;
  logic rst_n;
  floppy_emu_if bus();

  floppy_emu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #70 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: collect bits, ignore zeros before a byte starts,
  // emit after eight bits have been gathered.
  int       expQ[$];
  int       mLen   = 0;
  bit [7:0] mAcc   = 8'h00;
  int       mLast  = 0;
  int       mPar   = 0;

  // Observed completed bytes from the toggle strobe.
  int obsQ[$];
  int totToggles = 0;
  logic lastAck = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lastAck = 1'b0;
    end else if (bus.rdAckWrByte !== lastAck) begin
      obsQ.push_back(int'(bus.wrData));
      totToggles = totToggles + 1;
      lastAck = bus.rdAckWrByte;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelPush(input bit b);
    if (mLen == 0 && !b) return;
    mAcc = {mAcc[6:0], b};
    mLen++;
    if (mLen == 8) begin
      expQ.push_back(int'(mAcc));
      mLast = int'(mAcc);
      mPar  = mPar ^ 1;
      mLen  = 0;
    end
  endfunction

  function automatic void modelReset();
    mLen  = 0;
    mAcc  = 8'h00;
    mLast = 0;
    mPar  = 0;
    expQ.delete();
  endfunction

  // One 2 us cell; a 1 bit is a transition near mid-cell, optionally jittered.
  task automatic sendCell(input bit b, input int jitMax);
    int j;
    j = (jitMax > 0) ? (int'($urandom_range(0, 2 * jitMax)) - jitMax) : 0;
    if (b) begin
      #(1000 + j);
      bus.wr = ~bus.wr;
      #(1000 - j);
    end else begin
      #2000;
    end
    modelPush(b);
  endtask

  task automatic sendByte(input bit [7:0] v, input int jitMax);
    for (int i = 7; i >= 0; i--) sendCell(v[i], jitMax);
  endtask

  task automatic sendIdle(input int cells);
    for (int i = 0; i < cells; i++) sendCell(1'b0, 0);
  endtask

  // Let the pipeline drain, then compare every byte and the held outputs.
  task automatic flush(input string tag);
    int e;
    repeat (20) @(posedge clk);
    @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsQ.size() > 0) check({tag, "_byte"}, obsQ.pop_front(), e);
      else check({tag, "_missing"}, -1, e);
    end
    check({tag, "_extra"}, obsQ.size(), 0);
    obsQ.delete();
    check({tag, "_wrData"}, int'(bus.wrData), mLast);
    check({tag, "_ackLvl"}, int'(bus.rdAckWrByte), mPar);
  endtask

  function automatic bit has3Zeros(input bit [7:0] v);
    for (int i = 0; i <= 5; i++) if (v[i +: 3] == 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bit [7:0] rb;
    int       holdVal;
    bus.wr = 1'b0;
    rst_n  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_wrData", int'(bus.wrData), 0);
    check("rst_ack", int'(bus.rdAckWrByte), 0);
    rst_n = 1'b1;

    // Idle after reset: nothing decoded.
    sendIdle(5);
    flush("idle_reset");

    // Five 10-bit sync groups.
    for (int i = 0; i < 5; i++) begin
      sendByte(8'hFF, 0);
      sendIdle(2);
    end
    flush("sync");

    // Address-field style prologue and data.
    sendByte(8'hD5, 0);
    sendByte(8'hAA, 0);
    sendByte(8'h96, 0);
    sendByte(8'h96, 0);
    sendIdle(2);
    flush("data");
    check("total_toggles", totToggles, 9);

    // Jittered edges.
    sendByte(8'hD5, 300);
    sendIdle(2);
    flush("jitter");

    // Random legal GCR stream (MSB set, never three zeros in a row).
    for (int i = 0; i < 24; i++) begin
      do rb = 8'($urandom) | 8'h80; while (has3Zeros(rb));
      sendByte(rb, 250);
    end
    sendIdle(3);
    flush("rand");

    // Reset in the middle of a byte.
    sendCell(1'b1, 0); sendCell(1'b1, 0); sendCell(1'b0, 0);
    sendCell(1'b1, 0); sendCell(1'b0, 0); sendCell(1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    bus.wr = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_wrData", int'(bus.wrData), 0);
    check("midrst_ack", int'(bus.rdAckWrByte), 0);
    obsQ.delete();
    rst_n = 1'b1;
    sendIdle(1);
    sendByte(8'hAA, 0);
    sendIdle(2);
    flush("after_rst");

    // Long idle holds the last byte.
    holdVal = mLast;
    sendIdle(50);
    flush("idle_hold");
    check("idle_hold_val", int'(bus.wrData), holdVal);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
